bp_cce_mem_initiator: RTL and testbench
=======================================

Name: bp_cce_mem_initiator

Overview:
- CCE-side master for the CCE↔memory interface: the initiator opposite the memory responder (bp_mem).
- Takes one block-level transaction at a time from CCE-internal logic: a read fill or a writeback.
- Drives the mem_cmd / mem_data_cmd channels (valid→yumi) and consumes the mem_resp / mem_data_resp channels (ready→valid).
- Returns the completed transaction to the client.

Parameters:
- addr_width_p, 22, physical block address width.
- block_size_in_bits_p, 512, cache block data width.
- lce_id_width_p, 1, LCE id field width.
- way_id_width_p, 3, way id field width (log2 of lce_assoc).
- timeout_cycles_p, 1024, watchdog limit in WAIT; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- req_v_i  in  1  client request valid.
- req_ready_o  out  1  client request ready.
- req_wr_i  in  1  1 = writeback, 0 = read.
- req_addr_i  in  addr_width_p  request address.
- req_lce_id_i  in  lce_id_width_p  requesting LCE.
- req_way_i  in  way_id_width_p  target way.
- req_data_i  in  block_size_in_bits_p  writeback data.
- resp_v_o  out  1  completion valid.
- resp_yumi_i  in  1  client consumes completion.
- resp_wr_o  out  1  completion type.
- resp_addr_o  out  addr_width_p  completion address.
- resp_lce_id_o  out  lce_id_width_p  completion LCE id.
- resp_way_o  out  way_id_width_p  completion way.
- resp_data_o  out  block_size_in_bits_p  read data (0 for writeback).
- mem_cmd_v_o  out  1  read command valid.
- mem_cmd_yumi_i  in  1  memory consumes command.
- mem_cmd_addr_o / mem_cmd_lce_id_o / mem_cmd_way_o  out  addr/lce/way widths  command fields.
- mem_data_cmd_v_o  out  1  writeback command valid.
- mem_data_cmd_yumi_i  in  1  memory consumes writeback.
- mem_data_cmd_addr_o / _lce_id_o / _way_o / _data_o  out  field widths  writeback fields.
- mem_resp_v_i  in  1  writeback ack valid.
- mem_resp_ready_o  out  1  ack ready.
- mem_resp_addr_i / _lce_id_i / _way_i  in  field widths  ack fields.
- mem_data_resp_v_i  in  1  read data valid.
- mem_data_resp_ready_o  out  1  read data ready.
- mem_data_resp_addr_i / _lce_id_i / _way_i / _data_i  in  field widths  fill fields.
- err_o  out  1  sticky protocol error.
- timeout_o  out  1  sticky watchdog flag.

Behaviour:
- States: IDLE, SEND, WAIT, RESP. Reset (async, reset_n_i low) forces IDLE from any state.
- Reset values: all valid and ready outputs 0, err_o 0, timeout_o 0, transaction registers 0.
- IDLE:
  - req_ready_o=1 only when reset_n_i is high.
  - On req_v_i & req_ready_o, latch all req fields, go to SEND.
- SEND:
  - Cycle after acceptance: assert mem_cmd_v_o (read) or mem_data_cmd_v_o (write), never both.
  - Fields come from the latched registers and are stable while valid.
  - Valid is held until the matching yumi. Yumi may arrive in the first valid cycle.
  - On yumi, go to WAIT; valid drops the next cycle.
- WAIT:
  - Read: mem_data_resp_ready_o=1, mem_resp_ready_o=0.
  - Write: mem_resp_ready_o=1, mem_data_resp_ready_o=0.
  - Traffic on the non-ready channel is not accepted and has no effect.
  - On handshake, capture response data (reads) and go to RESP.
  - If the response addr, lce_id or way differs from the latched values, set err_o (sticky until reset). The transaction still completes, reporting the latched addr/lce_id/way.
- RESP:
  - resp_v_o=1 with the latched fields; resp_data_o holds captured data for reads, 0 for writes.
  - Held until resp_yumi_i, then go to IDLE.
  - req_ready_o stays 0 until IDLE, so a new request is accepted no earlier than the cycle after yumi.
- Minimum latency, request accept to resp_v_o: 3 cycles (yumi on first SEND cycle, response on first WAIT cycle).
- At most one outstanding transaction. No pipelining.
- Reset mid-transaction drops the transaction; no partial outputs follow reset release.

Optional Feature:
- Macro: BP_CCE_MEM_INITIATOR_TIMEOUT_EN.
- When defined:
  - 16-bit counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches timeout_cycles_p-1 without a response, timeout_o sets (sticky until reset). The counter saturates.
  - The FSM keeps waiting; a late response completes normally.
- When undefined: no counter; timeout_o is tied to 0.

Test Plan:
- Read addr=0x12345, lce=0, way=5:
  - mem_cmd_v_o in the cycle after accept, yumi same cycle.
  - mem_data_resp returns data=0xA5 repeated after 4 cycles.
  - resp_v_o with resp_data_o=0xA5 pattern, resp_wr_o=0, err_o=0.
- Writeback addr=0x00040, data=0xDEADBEEF, with mem_data_cmd_yumi_i delayed 6 cycles:
  - mem_data_cmd_v_o held 7 cycles with fields stable.
  - After mem_resp, resp_v_o=1, resp_wr_o=1, resp_data_o=0.
- During a read WAIT, drive mem_resp_v_i=1:
  - mem_resp_ready_o=0, no state change.
  - Subsequent mem_data_resp completes normally.
- Read response returns addr 0x12346 against latched 0x12345:
  - err_o=1 and stays 1.
  - resp_addr_o=0x12345.
- Assert reset_n_i low during WAIT for 1 cycle:
  - Next cycle all valids 0 and state IDLE.
  - req_ready_o=1 after release; a fresh read completes.
- With TIMEOUT_EN and timeout_cycles_p=8, withhold the response for 20 cycles:
  - timeout_o rises on the 8th WAIT cycle.
  - A later response still produces resp_v_o; timeout_o stays 1.

Source files
------------

// File: rtl/bp_cce_mem_initiator.sv
// CCE-side memory initiator: one read fill or writeback at a time, from client request to completion.
// Optional watchdog in WAIT enabled by defining BP_CCE_MEM_INITIATOR_TIMEOUT_EN.
//
// state  | meaning
// -------+------------------------------------------------------------
// e_idle | ready for a client request
// e_send | mem_cmd (read) or mem_data_cmd (write) valid, awaiting yumi
// e_wait | response channel ready, awaiting memory response
// e_resp | completion presented to client, awaiting resp_yumi_i

module bp_cce_mem_initiator #(
    parameter int addr_width_p         = 22,
    parameter int block_size_in_bits_p = 512,
    parameter int lce_id_width_p       = 1,
    parameter int way_id_width_p       = 3,
    parameter int timeout_cycles_p     = 1024
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,

    input  logic                            req_v_i,
    output logic                            req_ready_o,
    input  logic                            req_wr_i,
    input  logic [addr_width_p-1:0]         req_addr_i,
    input  logic [lce_id_width_p-1:0]       req_lce_id_i,
    input  logic [way_id_width_p-1:0]       req_way_i,
    input  logic [block_size_in_bits_p-1:0] req_data_i,

    output logic                            resp_v_o,
    input  logic                            resp_yumi_i,
    output logic                            resp_wr_o,
    output logic [addr_width_p-1:0]         resp_addr_o,
    output logic [lce_id_width_p-1:0]       resp_lce_id_o,
    output logic [way_id_width_p-1:0]       resp_way_o,
    output logic [block_size_in_bits_p-1:0] resp_data_o,

    output logic                            mem_cmd_v_o,
    input  logic                            mem_cmd_yumi_i,
    output logic [addr_width_p-1:0]         mem_cmd_addr_o,
    output logic [lce_id_width_p-1:0]       mem_cmd_lce_id_o,
    output logic [way_id_width_p-1:0]       mem_cmd_way_o,

    output logic                            mem_data_cmd_v_o,
    input  logic                            mem_data_cmd_yumi_i,
    output logic [addr_width_p-1:0]         mem_data_cmd_addr_o,
    output logic [lce_id_width_p-1:0]       mem_data_cmd_lce_id_o,
    output logic [way_id_width_p-1:0]       mem_data_cmd_way_o,
    output logic [block_size_in_bits_p-1:0] mem_data_cmd_data_o,

    input  logic                            mem_resp_v_i,
    output logic                            mem_resp_ready_o,
    input  logic [addr_width_p-1:0]         mem_resp_addr_i,
    input  logic [lce_id_width_p-1:0]       mem_resp_lce_id_i,
    input  logic [way_id_width_p-1:0]       mem_resp_way_i,

    input  logic                            mem_data_resp_v_i,
    output logic                            mem_data_resp_ready_o,
    input  logic [addr_width_p-1:0]         mem_data_resp_addr_i,
    input  logic [lce_id_width_p-1:0]       mem_data_resp_lce_id_i,
    input  logic [way_id_width_p-1:0]       mem_data_resp_way_i,
    input  logic [block_size_in_bits_p-1:0] mem_data_resp_data_i,

    output logic                            err_o,
    output logic                            timeout_o
);

    typedef enum logic [1:0] {e_idle, e_send, e_wait, e_resp} state_e;

    state_e                          state_r;
    logic                            wr_r;
    logic [addr_width_p-1:0]         addr_r;
    logic [lce_id_width_p-1:0]       lce_r;
    logic [way_id_width_p-1:0]       way_r;
    logic [block_size_in_bits_p-1:0] data_r;
    logic                            cmd_v_r;
    logic                            data_cmd_v_r;
    logic                            resp_ready_r;
    logic                            data_resp_ready_r;
    logic                            resp_v_r;
    logic                            err_r;

    logic send_done;
    logic rd_hs;
    logic wr_hs;
    logic rd_mismatch;
    logic wr_mismatch;

    assign send_done   = (cmd_v_r & mem_cmd_yumi_i) | (data_cmd_v_r & mem_data_cmd_yumi_i);
    assign rd_hs       = data_resp_ready_r & mem_data_resp_v_i;
    assign wr_hs       = resp_ready_r & mem_resp_v_i;
    assign rd_mismatch = (mem_data_resp_addr_i != addr_r) | (mem_data_resp_lce_id_i != lce_r)
                       | (mem_data_resp_way_i != way_r);
    assign wr_mismatch = (mem_resp_addr_i != addr_r) | (mem_resp_lce_id_i != lce_r)
                       | (mem_resp_way_i != way_r);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r           <= e_idle;
            wr_r              <= 1'b0;
            addr_r            <= '0;
            lce_r             <= '0;
            way_r             <= '0;
            data_r            <= '0;
            cmd_v_r           <= 1'b0;
            data_cmd_v_r      <= 1'b0;
            resp_ready_r      <= 1'b0;
            data_resp_ready_r <= 1'b0;
            resp_v_r          <= 1'b0;
            err_r             <= 1'b0;
        end else begin
            case (state_r)
                e_idle: begin
                    if (req_v_i) begin
                        wr_r         <= req_wr_i;
                        addr_r       <= req_addr_i;
                        lce_r        <= req_lce_id_i;
                        way_r        <= req_way_i;
                        data_r       <= req_data_i;
                        cmd_v_r      <= ~req_wr_i;
                        data_cmd_v_r <= req_wr_i;
                        state_r      <= e_send;
                    end
                end
                e_send: begin
                    if (send_done) begin
                        cmd_v_r           <= 1'b0;
                        data_cmd_v_r      <= 1'b0;
                        resp_ready_r      <= wr_r;
                        data_resp_ready_r <= ~wr_r;
                        state_r           <= e_wait;
                    end
                end
                e_wait: begin
                    if (rd_hs | wr_hs) begin
                        resp_ready_r      <= 1'b0;
                        data_resp_ready_r <= 1'b0;
                        // writeback data is no longer needed; completion reports zero data
                        data_r            <= wr_r ? '0 : mem_data_resp_data_i;
                        if (rd_hs ? rd_mismatch : wr_mismatch)
                            err_r <= 1'b1;
                        resp_v_r          <= 1'b1;
                        state_r           <= e_resp;
                    end
                end
                e_resp: begin
                    if (resp_yumi_i) begin
                        resp_v_r <= 1'b0;
                        state_r  <= e_idle;
                    end
                end
                default: state_r <= e_idle;
            endcase
        end
    end

    assign req_ready_o           = reset_n_i & (state_r == e_idle);
    assign resp_v_o              = resp_v_r;
    assign resp_wr_o             = wr_r;
    assign resp_addr_o           = addr_r;
    assign resp_lce_id_o         = lce_r;
    assign resp_way_o            = way_r;
    assign resp_data_o           = data_r;
    assign mem_cmd_v_o           = cmd_v_r;
    assign mem_cmd_addr_o        = addr_r;
    assign mem_cmd_lce_id_o      = lce_r;
    assign mem_cmd_way_o         = way_r;
    assign mem_data_cmd_v_o      = data_cmd_v_r;
    assign mem_data_cmd_addr_o   = addr_r;
    assign mem_data_cmd_lce_id_o = lce_r;
    assign mem_data_cmd_way_o    = way_r;
    assign mem_data_cmd_data_o   = data_r;
    assign mem_resp_ready_o      = resp_ready_r;
    assign mem_data_resp_ready_o = data_resp_ready_r;
    assign err_o                 = err_r;

`ifdef BP_CCE_MEM_INITIATOR_TIMEOUT_EN
    localparam logic [15:0] tc_limit_lp = 16'(timeout_cycles_p - 1);

    logic [15:0] wait_cnt_r;
    logic        timeout_r;

    // Counter value in WAIT cycle k is k-1; the flag is visible from the cycle the limit is reached.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wait_cnt_r <= '0;
            timeout_r  <= 1'b0;
        end else if (state_r == e_send && send_done) begin
            wait_cnt_r <= '0;
            if (tc_limit_lp == 16'd0)
                timeout_r <= 1'b1;
        end else if (state_r == e_wait && !(rd_hs | wr_hs) && wait_cnt_r != tc_limit_lp) begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
            if (wait_cnt_r + 16'd1 == tc_limit_lp)
                timeout_r <= 1'b1;
        end
    end

    assign timeout_o = timeout_r;
`else
    logic unused_timeout;
    assign unused_timeout = (timeout_cycles_p != 0);
    assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_bp_cce_mem_initiator.sv
// Directed self-checking bench for bp_cce_mem_initiator.
// Watchdog checks adapt to whether BP_CCE_MEM_INITIATOR_TIMEOUT_EN is defined.

module tb_bp_cce_mem_initiator;

    localparam int AW = 22;
    localparam int BW = 512;
    localparam int LW = 1;
    localparam int WW = 3;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          req_v_i, req_ready_o, req_wr_i;
    logic [AW-1:0] req_addr_i;
    logic [LW-1:0] req_lce_id_i;
    logic [WW-1:0] req_way_i;
    logic [BW-1:0] req_data_i;
    logic          resp_v_o, resp_yumi_i, resp_wr_o;
    logic [AW-1:0] resp_addr_o;
    logic [LW-1:0] resp_lce_id_o;
    logic [WW-1:0] resp_way_o;
    logic [BW-1:0] resp_data_o;
    logic          mem_cmd_v_o, mem_cmd_yumi_i;
    logic [AW-1:0] mem_cmd_addr_o;
    logic [LW-1:0] mem_cmd_lce_id_o;
    logic [WW-1:0] mem_cmd_way_o;
    logic          mem_data_cmd_v_o, mem_data_cmd_yumi_i;
    logic [AW-1:0] mem_data_cmd_addr_o;
    logic [LW-1:0] mem_data_cmd_lce_id_o;
    logic [WW-1:0] mem_data_cmd_way_o;
    logic [BW-1:0] mem_data_cmd_data_o;
    logic          mem_resp_v_i, mem_resp_ready_o;
    logic [AW-1:0] mem_resp_addr_i;
    logic [LW-1:0] mem_resp_lce_id_i;
    logic [WW-1:0] mem_resp_way_i;
    logic          mem_data_resp_v_i, mem_data_resp_ready_o;
    logic [AW-1:0] mem_data_resp_addr_i;
    logic [LW-1:0] mem_data_resp_lce_id_i;
    logic [WW-1:0] mem_data_resp_way_i;
    logic [BW-1:0] mem_data_resp_data_i;
    logic          err_o, timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [BW-1:0] pat_a5;
    logic [BW-1:0] pat_b;
    logic [BW-1:0] pat_c;
    logic          exp_to;

    bp_cce_mem_initiator #(
        .addr_width_p(AW), .block_size_in_bits_p(BW), .lce_id_width_p(LW),
        .way_id_width_p(WW), .timeout_cycles_p(8)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_wr_i(req_wr_i),
        .req_addr_i(req_addr_i), .req_lce_id_i(req_lce_id_i), .req_way_i(req_way_i),
        .req_data_i(req_data_i),
        .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i), .resp_wr_o(resp_wr_o),
        .resp_addr_o(resp_addr_o), .resp_lce_id_o(resp_lce_id_o), .resp_way_o(resp_way_o),
        .resp_data_o(resp_data_o),
        .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
        .mem_cmd_addr_o(mem_cmd_addr_o), .mem_cmd_lce_id_o(mem_cmd_lce_id_o),
        .mem_cmd_way_o(mem_cmd_way_o),
        .mem_data_cmd_v_o(mem_data_cmd_v_o), .mem_data_cmd_yumi_i(mem_data_cmd_yumi_i),
        .mem_data_cmd_addr_o(mem_data_cmd_addr_o), .mem_data_cmd_lce_id_o(mem_data_cmd_lce_id_o),
        .mem_data_cmd_way_o(mem_data_cmd_way_o), .mem_data_cmd_data_o(mem_data_cmd_data_o),
        .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_o(mem_resp_ready_o),
        .mem_resp_addr_i(mem_resp_addr_i), .mem_resp_lce_id_i(mem_resp_lce_id_i),
        .mem_resp_way_i(mem_resp_way_i),
        .mem_data_resp_v_i(mem_data_resp_v_i), .mem_data_resp_ready_o(mem_data_resp_ready_o),
        .mem_data_resp_addr_i(mem_data_resp_addr_i), .mem_data_resp_lce_id_i(mem_data_resp_lce_id_i),
        .mem_data_resp_way_i(mem_data_resp_way_i), .mem_data_resp_data_i(mem_data_resp_data_i),
        .err_o(err_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present a request for one edge; afterwards the DUT is in SEND.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l,
                         input logic [WW-1:0] w, input logic [BW-1:0] d);
        req_v_i = 1'b1; req_wr_i = wr; req_addr_i = a; req_lce_id_i = l;
        req_way_i = w; req_data_i = d;
        step();
        req_v_i = 1'b0;
    endtask

    task automatic cmd_yumi_now();
        mem_cmd_yumi_i = 1'b1;
        step();
        mem_cmd_yumi_i = 1'b0;
    endtask

    task automatic data_resp(input logic [AW-1:0] a, input logic [LW-1:0] l,
                             input logic [WW-1:0] w, input logic [BW-1:0] d);
        mem_data_resp_v_i = 1'b1; mem_data_resp_addr_i = a; mem_data_resp_lce_id_i = l;
        mem_data_resp_way_i = w; mem_data_resp_data_i = d;
        step();
        mem_data_resp_v_i = 1'b0;
    endtask

    task automatic consume();
        resp_yumi_i = 1'b1;
        step();
        resp_yumi_i = 1'b0;
    endtask

    initial begin
        pat_a5 = {64{8'hA5}};
        pat_b  = {16{32'h0123_4567}};
        pat_c  = {32{16'h5A3C}};
        reset_n_i = 1'b0;
        req_v_i = 0; req_wr_i = 0; req_addr_i = '0; req_lce_id_i = '0; req_way_i = '0; req_data_i = '0;
        resp_yumi_i = 0; mem_cmd_yumi_i = 0; mem_data_cmd_yumi_i = 0;
        mem_resp_v_i = 0; mem_resp_addr_i = '0; mem_resp_lce_id_i = '0; mem_resp_way_i = '0;
        mem_data_resp_v_i = 0; mem_data_resp_addr_i = '0; mem_data_resp_lce_id_i = '0;
        mem_data_resp_way_i = '0; mem_data_resp_data_i = '0;

        step(); step();
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_cmd_v", mem_cmd_v_o, 0);
        chk("rst_dcmd_v", mem_data_cmd_v_o, 0);
        chk("rst_resp_v", resp_v_o, 0);
        chk("rst_dresp_ready", mem_data_resp_ready_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_timeout", timeout_o, 0);
        reset_n_i = 1'b1;
        #1;
        chk("rel_req_ready", req_ready_o, 1);

        // Read with immediate yumi and data returned after 4 WAIT cycles.
        issue(1'b0, 22'h12345, 1'b0, 3'd5, '0);
        chk("rd_cmd_v", mem_cmd_v_o, 1);
        chk("rd_dcmd_v", mem_data_cmd_v_o, 0);
        chk("rd_cmd_addr", mem_cmd_addr_o, 22'h12345);
        chk("rd_cmd_way", mem_cmd_way_o, 5);
        chk("rd_req_ready", req_ready_o, 0);
        cmd_yumi_now();
        chk("rd_cmd_v_drop", mem_cmd_v_o, 0);
        chk("rd_dresp_ready", mem_data_resp_ready_o, 1);
        chk("rd_resp_ready", mem_resp_ready_o, 0);
        step(); step(); step();
        chk("rd_wait_resp_v", resp_v_o, 0);
        data_resp(22'h12345, 1'b0, 3'd5, pat_a5);
        chk("rd_resp_v", resp_v_o, 1);
        chk("rd_resp_data", resp_data_o, pat_a5);
        chk("rd_resp_wr", resp_wr_o, 0);
        chk("rd_resp_addr", resp_addr_o, 22'h12345);
        chk("rd_resp_way", resp_way_o, 5);
        chk("rd_err", err_o, 0);
        chk("rd_hold_ready", req_ready_o, 0);
        step();
        chk("rd_resp_held", resp_v_o, 1);
        consume();
        chk("rd_resp_v_drop", resp_v_o, 0);
        chk("rd_back_idle", req_ready_o, 1);

        // Writeback with yumi delayed 6 cycles: valid held 7 cycles.
        issue(1'b1, 22'h00040, 1'b1, 3'd2, {480'h0, 32'hDEADBEEF});
        for (int i = 0; i < 7; i++) begin
            chk("wb_dcmd_v", mem_data_cmd_v_o, 1);
            chk("wb_cmd_v", mem_cmd_v_o, 0);
            chk("wb_addr", mem_data_cmd_addr_o, 22'h00040);
            chk("wb_data", mem_data_cmd_data_o, {480'h0, 32'hDEADBEEF});
            if (i == 6) mem_data_cmd_yumi_i = 1'b1;
            step();
        end
        mem_data_cmd_yumi_i = 1'b0;
        chk("wb_dcmd_v_drop", mem_data_cmd_v_o, 0);
        chk("wb_resp_ready", mem_resp_ready_o, 1);
        chk("wb_dresp_ready", mem_data_resp_ready_o, 0);
        mem_resp_v_i = 1'b1; mem_resp_addr_i = 22'h00040; mem_resp_lce_id_i = 1'b1; mem_resp_way_i = 3'd2;
        step();
        mem_resp_v_i = 1'b0;
        chk("wb_resp_v", resp_v_o, 1);
        chk("wb_resp_wr", resp_wr_o, 1);
        chk("wb_resp_data", resp_data_o, 0);
        chk("wb_resp_lce", resp_lce_id_o, 1);
        chk("wb_err", err_o, 0);
        consume();

        // Stray traffic on the write-ack channel during a read WAIT is ignored.
        issue(1'b0, 22'h00100, 1'b1, 3'd7, '0);
        cmd_yumi_now();
        mem_resp_v_i = 1'b1; mem_resp_addr_i = 22'h3FFFF; mem_resp_lce_id_i = 1'b0; mem_resp_way_i = 3'd0;
        for (int i = 0; i < 3; i++) begin
            chk("stray_resp_ready", mem_resp_ready_o, 0);
            step();
            chk("stray_resp_v", resp_v_o, 0);
            chk("stray_dresp_ready", mem_data_resp_ready_o, 1);
        end
        mem_resp_v_i = 1'b0;
        data_resp(22'h00100, 1'b1, 3'd7, pat_b);
        chk("stray_done_v", resp_v_o, 1);
        chk("stray_done_data", resp_data_o, pat_b);
        chk("stray_err", err_o, 0);
        consume();

        // Mismatched response address at minimum latency: err sets and sticks.
        issue(1'b0, 22'h12345, 1'b0, 3'd5, '0);
        cmd_yumi_now();
        chk("mm_wait_resp_v", resp_v_o, 0);
        data_resp(22'h12346, 1'b0, 3'd5, pat_c);
        chk("mm_min_lat_v", resp_v_o, 1);
        chk("mm_err", err_o, 1);
        chk("mm_resp_addr", resp_addr_o, 22'h12345);
        chk("mm_resp_data", resp_data_o, pat_c);
        consume();
        step();
        chk("mm_err_sticky", err_o, 1);

        // Reset during WAIT drops the transaction.
        issue(1'b0, 22'h00777, 1'b1, 3'd3, '0);
        cmd_yumi_now();
        chk("rw_in_wait", mem_data_resp_ready_o, 1);
        reset_n_i = 1'b0;
        step();
        chk("rw_cmd_v", mem_cmd_v_o, 0);
        chk("rw_dcmd_v", mem_data_cmd_v_o, 0);
        chk("rw_resp_v", resp_v_o, 0);
        chk("rw_dresp_ready", mem_data_resp_ready_o, 0);
        chk("rw_err_clr", err_o, 0);
        reset_n_i = 1'b1;
        #1;
        chk("rw_req_ready", req_ready_o, 1);
        step();
        chk("rw_no_resp", resp_v_o, 0);
        issue(1'b0, 22'h00888, 1'b0, 3'd1, '0);
        cmd_yumi_now();
        data_resp(22'h00888, 1'b0, 3'd1, pat_a5);
        chk("rw_fresh_v", resp_v_o, 1);
        chk("rw_fresh_addr", resp_addr_o, 22'h00888);
        chk("rw_fresh_data", resp_data_o, pat_a5);
        consume();

        // Withheld response for 20 WAIT cycles, then a late response.
        issue(1'b0, 22'h00ABC, 1'b1, 3'd4, '0);
        cmd_yumi_now();
        for (int k = 1; k <= 20; k++) begin
`ifdef BP_CCE_MEM_INITIATOR_TIMEOUT_EN
            exp_to = (k >= 8);
`else
            exp_to = 1'b0;
`endif
            chk("to_flag", timeout_o, exp_to);
            chk("to_resp_v", resp_v_o, 0);
            step();
        end
        data_resp(22'h00ABC, 1'b1, 3'd4, pat_b);
        chk("to_late_v", resp_v_o, 1);
        chk("to_late_data", resp_data_o, pat_b);
`ifdef BP_CCE_MEM_INITIATOR_TIMEOUT_EN
        chk("to_sticky", timeout_o, 1);
`else
        chk("to_tied", timeout_o, 0);
`endif
        consume();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
